ma_stage: RTL and testbench

Memory-access stage of the 32-bit in-order pipeline. It consumes the execute-stage payload (`Ex_Ma_t`) through a valid/ready handshake and performs loads and stores against the data memory over a request/grant/response port. It forwards non-memory instructions unchanged and delivers a `Ma_Rw_t` payload to the register-writeback stage through a single-entry output register.

---
 rtl/ma_stage.sv | 159 +++++++++++++++
 tb/tb_ma_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage.sv
// Memory-access stage: issues loads/stores to data memory, forwards ALU results,
// and hands a single registered payload to register writeback.
package ma_stage_pkg;

    typedef struct packed {
        logic       isLd;
        logic       isSt;
        logic       regWe;
        logic [4:0] rd;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] aluresult;
        logic [31:0] op2;
        logic [31:0] instr;
        ctrl_t       ctrl;
    } Ex_Ma_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] aluresult;
        logic [31:0] ldresult;
        logic [31:0] instr;
        ctrl_t       ctrl;
    } Ma_Rw_t;

endpackage

module ma_stage
    import ma_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  Ex_Ma_t      Ex_Payld_i,
    input  logic        Ex_Valid_i,
    output logic        Ex_Ready_o,
    output Ma_Rw_t      Ma_Payld_o,
    output logic        Ma_Valid_o,
    input  logic        Ma_Ready_i,
    output logic        Dmem_Req_o,
    output logic        Dmem_We_o,
    output logic [31:0] Dmem_Addr_o,
    output logic [31:0] Dmem_Wdata_o,
    input  logic        Dmem_Gnt_i,
    input  logic        Dmem_Rvalid_i,
    input  logic [31:0] Dmem_Rdata_i,
    output logic        Ma_Err_o,
    output logic        Busy_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state;
    logic [CW-1:0]   tmo_cnt;
    logic [CW-1:0]   cnt_inc;
    Ex_Ma_t          hold_q;
    Ma_Rw_t          out_q;
    logic            out_valid_q;
    logic            err_q;
    logic            accept;
    logic            is_mem;
    logic            misaligned;
    logic            timed_out;

    function automatic Ma_Rw_t to_out(input Ex_Ma_t p, input logic [31:0] ld);
        Ma_Rw_t r;
        r.pc        = p.pc;
        r.aluresult = p.aluresult;
        r.ldresult  = ld;
        r.instr     = p.instr;
        r.ctrl      = p.ctrl;
        return r;
    endfunction

    assign Ex_Ready_o = (state == IDLE) && (!out_valid_q || Ma_Ready_i);
    assign accept     = Ex_Valid_i && Ex_Ready_o;
    assign is_mem     = Ex_Payld_i.ctrl.isLd || Ex_Payld_i.ctrl.isSt;
    assign misaligned = (Ex_Payld_i.aluresult[1:0] != 2'b00);
    assign cnt_inc    = tmo_cnt + CW'(1);
    assign timed_out  = (cnt_inc == CW'(TIMEOUT));

    // Memory-side outputs decode straight from state so reset drops the request at once.
    assign Dmem_Req_o   = (state == REQ);
    assign Dmem_We_o    = Dmem_Req_o && hold_q.ctrl.isSt;
    assign Dmem_Addr_o  = Dmem_Req_o ? hold_q.aluresult : 32'h0;
    assign Dmem_Wdata_o = Dmem_Req_o ? hold_q.op2 : 32'h0;

    assign Ma_Payld_o = out_q;
    assign Ma_Valid_o = out_valid_q;
    assign Ma_Err_o   = err_q;
    assign Busy_o     = (state != IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            hold_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (out_valid_q && Ma_Ready_i) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem || misaligned) begin
                            out_q       <= to_out(Ex_Payld_i, 32'h0);
                            out_valid_q <= 1'b1;
                            err_q       <= is_mem;
                        end else begin
                            hold_q  <= Ex_Payld_i;
                            tmo_cnt <= '0;
                            state   <= REQ;
                        end
                    end
                end
                // A granted store completes even on the final budget cycle; a load granted then is abandoned.
                REQ: begin
                    tmo_cnt <= cnt_inc;
                    if (Dmem_Gnt_i && hold_q.ctrl.isSt) begin
                        out_q       <= to_out(hold_q, 32'h0);
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                    end else if (timed_out) begin
                        out_q       <= to_out(hold_q, 32'h0);
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        state       <= IDLE;
                    end else if (Dmem_Gnt_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_cnt <= cnt_inc;
                    if (Dmem_Rvalid_i) begin
                        out_q       <= to_out(hold_q, Dmem_Rdata_i);
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                    end else if (timed_out) begin
                        out_q       <= to_out(hold_q, 32'h0);
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage: ALU forwarding, store/load latency, misalignment,
// timeout, backpressure and mid-transaction reset.
module tb_ma_stage;
    import ma_stage_pkg::*;

    localparam int TMO = 5;

    logic        Clk;
    logic        Rst_n;
    Ex_Ma_t      Ex_Payld_i;
    logic        Ex_Valid_i;
    logic        Ex_Ready_o;
    Ma_Rw_t      Ma_Payld_o;
    logic        Ma_Valid_o;
    logic        Ma_Ready_i;
    logic        Dmem_Req_o;
    logic        Dmem_We_o;
    logic [31:0] Dmem_Addr_o;
    logic [31:0] Dmem_Wdata_o;
    logic        Dmem_Gnt_i;
    logic        Dmem_Rvalid_i;
    logic [31:0] Dmem_Rdata_i;
    logic        Ma_Err_o;
    logic        Busy_o;

    int checks   = 0;
    int failures = 0;

    ma_stage #(.TIMEOUT(TMO)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Ex_Payld_i(Ex_Payld_i), .Ex_Valid_i(Ex_Valid_i), .Ex_Ready_o(Ex_Ready_o),
        .Ma_Payld_o(Ma_Payld_o), .Ma_Valid_o(Ma_Valid_o), .Ma_Ready_i(Ma_Ready_i),
        .Dmem_Req_o(Dmem_Req_o), .Dmem_We_o(Dmem_We_o), .Dmem_Addr_o(Dmem_Addr_o),
        .Dmem_Wdata_o(Dmem_Wdata_o), .Dmem_Gnt_i(Dmem_Gnt_i), .Dmem_Rvalid_i(Dmem_Rvalid_i),
        .Dmem_Rdata_i(Dmem_Rdata_i), .Ma_Err_o(Ma_Err_o), .Busy_o(Busy_o)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic ld, input logic st,
                                 input logic [31:0] pc, input logic [31:0] addr,
                                 input logic [31:0] data);
        Ex_Valid_i                 = valid;
        Ex_Payld_i                 = '0;
        Ex_Payld_i.pc              = pc;
        Ex_Payld_i.aluresult       = addr;
        Ex_Payld_i.op2             = data;
        Ex_Payld_i.instr           = 32'h0000_0013 ^ pc;
        Ex_Payld_i.ctrl.isLd       = ld;
        Ex_Payld_i.ctrl.isSt       = st;
        Ex_Payld_i.ctrl.regWe      = !st;
        Ex_Payld_i.ctrl.rd         = 5'd7;
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst_n         = 1'b0;
        Ma_Ready_i    = 1'b1;
        Dmem_Gnt_i    = 1'b0;
        Dmem_Rvalid_i = 1'b0;
        Dmem_Rdata_i  = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        checkOutput("rst_valid", Ma_Valid_o, 0);
        checkOutput("rst_req", Dmem_Req_o, 0);
        checkOutput("rst_we", Dmem_We_o, 0);
        checkOutput("rst_addr", Dmem_Addr_o, 0);
        checkOutput("rst_wdata", Dmem_Wdata_o, 0);
        checkOutput("rst_err", Ma_Err_o, 0);
        checkOutput("rst_busy", Busy_o, 0);
        checkOutput("rst_exready", Ex_Ready_o, 1);
        nextCycle();
        Rst_n = 1'b1;
        nextCycle();

        // Three back-to-back ALU ops; a misaligned-looking address is irrelevant for non-memory ops.
        $display("[TB] ALU back-to-back");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h10 + 32'(4 * i), 32'h1001 + 32'(i), 32'h0);
            checkOutput("alu_exready", Ex_Ready_o, 1);
            nextCycle();
            checkOutput("alu_valid", Ma_Valid_o, 1);
            checkOutput("alu_pc", Ma_Payld_o.pc, 32'h10 + 32'(4 * i));
            checkOutput("alu_res", Ma_Payld_o.aluresult, 32'h1001 + 32'(i));
            checkOutput("alu_ld", Ma_Payld_o.ldresult, 0);
            checkOutput("alu_err", Ma_Err_o, 0);
            checkOutput("alu_req", Dmem_Req_o, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        nextCycle();
        checkOutput("alu_drain", Ma_Valid_o, 0);

        // Store with grant delayed two cycles.
        $display("[TB] store delayed grant");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 32'h100, 32'hCAFEF00D);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            checkOutput("st_req", Dmem_Req_o, 1);
            checkOutput("st_we", Dmem_We_o, 1);
            checkOutput("st_addr", Dmem_Addr_o, 32'h100);
            checkOutput("st_wdata", Dmem_Wdata_o, 32'hCAFEF00D);
            checkOutput("st_exready", Ex_Ready_o, 0);
            checkOutput("st_valid", Ma_Valid_o, 0);
            if (i == 3) Dmem_Gnt_i = 1'b1;
            nextCycle();
        end
        Dmem_Gnt_i = 1'b0;
        checkOutput("st_done_valid", Ma_Valid_o, 1);
        checkOutput("st_done_pc", Ma_Payld_o.pc, 32'h100);
        checkOutput("st_done_ld", Ma_Payld_o.ldresult, 0);
        checkOutput("st_done_err", Ma_Err_o, 0);
        checkOutput("st_done_req", Dmem_Req_o, 0);
        checkOutput("st_done_addr", Dmem_Addr_o, 0);
        checkOutput("st_done_exready", Ex_Ready_o, 1);
        nextCycle();

        // Load, immediate grant, response three cycles after grant.
        $display("[TB] load delayed response");
        Dmem_Rdata_i = 32'h0BAD0BAD;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h204, 32'h40, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checkOutput("ld_req", Dmem_Req_o, 1);
        checkOutput("ld_we", Dmem_We_o, 0);
        checkOutput("ld_addr", Dmem_Addr_o, 32'h40);
        Dmem_Gnt_i = 1'b1;
        nextCycle();
        Dmem_Gnt_i = 1'b0;
        checkOutput("ld_wait_req", Dmem_Req_o, 0);
        checkOutput("ld_wait_busy", Busy_o, 1);
        nextCycle();
        checkOutput("ld_wait_valid", Ma_Valid_o, 0);
        nextCycle();
        Dmem_Rvalid_i = 1'b1;
        Dmem_Rdata_i  = 32'h12345678;
        nextCycle();
        Dmem_Rvalid_i = 1'b0;
        checkOutput("ld_valid", Ma_Valid_o, 1);
        checkOutput("ld_data", Ma_Payld_o.ldresult, 32'h12345678);
        checkOutput("ld_pc", Ma_Payld_o.pc, 32'h204);
        checkOutput("ld_err", Ma_Err_o, 0);
        nextCycle();
        checkOutput("ld_drain", Ma_Valid_o, 0);

        // Misaligned load retires at once with an error pulse.
        $display("[TB] misaligned load");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h42, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checkOutput("mis_req", Dmem_Req_o, 0);
        checkOutput("mis_valid", Ma_Valid_o, 1);
        checkOutput("mis_err", Ma_Err_o, 1);
        checkOutput("mis_ld", Ma_Payld_o.ldresult, 0);
        checkOutput("mis_busy", Busy_o, 0);
        nextCycle();
        checkOutput("mis_err_pulse", Ma_Err_o, 0);
        checkOutput("mis_drain", Ma_Valid_o, 0);

        // Load never granted: retires by timeout TMO+1 cycles after acceptance.
        $display("[TB] timeout");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h304, 32'h80, 32'h0);
        for (int i = 1; i <= TMO; i++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            checkOutput("tmo_req", Dmem_Req_o, 1);
            checkOutput("tmo_valid", Ma_Valid_o, 0);
            checkOutput("tmo_err_early", Ma_Err_o, 0);
        end
        nextCycle();
        checkOutput("tmo_valid_rise", Ma_Valid_o, 1);
        checkOutput("tmo_err", Ma_Err_o, 1);
        checkOutput("tmo_ld", Ma_Payld_o.ldresult, 0);
        checkOutput("tmo_pc", Ma_Payld_o.pc, 32'h304);
        checkOutput("tmo_req_off", Dmem_Req_o, 0);
        checkOutput("tmo_busy", Busy_o, 0);
        Dmem_Rvalid_i = 1'b1;
        Dmem_Rdata_i  = 32'h55;
        nextCycle();
        Dmem_Rvalid_i = 1'b0;
        checkOutput("stray_valid", Ma_Valid_o, 0);
        checkOutput("stray_err", Ma_Err_o, 0);
        checkOutput("stray_busy", Busy_o, 0);

        // Backpressure: ALU result stalls, following load waits until drain.
        $display("[TB] backpressure");
        Ma_Ready_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h200, 32'hABC, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h208, 32'h44, 32'h0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", Ma_Valid_o, 1);
            checkOutput("bp_pc", Ma_Payld_o.pc, 32'h200);
            checkOutput("bp_res", Ma_Payld_o.aluresult, 32'hABC);
            checkOutput("bp_exready", Ex_Ready_o, 0);
            checkOutput("bp_req", Dmem_Req_o, 0);
            if (i < 4) nextCycle();
        end
        Ma_Ready_i = 1'b1;
        #1;
        checkOutput("bp_exready_drain", Ex_Ready_o, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checkOutput("bp_drained", Ma_Valid_o, 0);
        checkOutput("bp_ld_req", Dmem_Req_o, 1);
        checkOutput("bp_ld_addr", Dmem_Addr_o, 32'h44);
        Dmem_Gnt_i = 1'b1;
        nextCycle();
        Dmem_Gnt_i    = 1'b0;
        Dmem_Rvalid_i = 1'b1;
        Dmem_Rdata_i  = 32'hA5A50001;
        nextCycle();
        Dmem_Rvalid_i = 1'b0;
        checkOutput("bp_ld_valid", Ma_Valid_o, 1);
        checkOutput("bp_ld_data", Ma_Payld_o.ldresult, 32'hA5A50001);
        checkOutput("bp_ld_pc", Ma_Payld_o.pc, 32'h208);
        nextCycle();

        // Reset while a load waits for its response, then a clean load.
        $display("[TB] reset during wait");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h400, 32'h48, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        Dmem_Gnt_i = 1'b1;
        nextCycle();
        Dmem_Gnt_i = 1'b0;
        checkOutput("rw_busy_pre", Busy_o, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        checkOutput("rw_busy", Busy_o, 0);
        checkOutput("rw_req", Dmem_Req_o, 0);
        checkOutput("rw_valid", Ma_Valid_o, 0);
        checkOutput("rw_err", Ma_Err_o, 0);
        checkOutput("rw_exready", Ex_Ready_o, 1);
        nextCycle();
        Rst_n = 1'b1;
        nextCycle();
        checkOutput("rw_post_valid", Ma_Valid_o, 0);
        checkOutput("rw_post_err", Ma_Err_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h404, 32'h4C, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checkOutput("rw_ld_req", Dmem_Req_o, 1);
        checkOutput("rw_ld_addr", Dmem_Addr_o, 32'h4C);
        Dmem_Gnt_i = 1'b1;
        nextCycle();
        Dmem_Gnt_i    = 1'b0;
        Dmem_Rvalid_i = 1'b1;
        Dmem_Rdata_i  = 32'h600DF00D;
        nextCycle();
        Dmem_Rvalid_i = 1'b0;
        checkOutput("rw_ld_valid", Ma_Valid_o, 1);
        checkOutput("rw_ld_data", Ma_Payld_o.ldresult, 32'h600DF00D);
        checkOutput("rw_ld_pc", Ma_Payld_o.pc, 32'h404);
        checkOutput("rw_ld_err", Ma_Err_o, 0);
        nextCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
